regfile_wb_arbiter: RTL and testbench
=====================================

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of entries in the MDU writeback buffer (power of two, >=2).
REQ-002 SHALL have parameter MAX_WAIT, default 4, meaning the number of cycles the buffer head may wait before a pipeline stall is forced.
REQ-003 CLK  in  1  the only clock; all state updates on its rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 aValid  in  1  pipeline WB-stage write request; it has no backpressure.
REQ-006 aReg  in  5  pipeline destination register.
REQ-007 aData  in  32  pipeline write data.
REQ-008 bValid  in  1  multi-cycle unit (MDU) result valid.
REQ-009 bReg  in  5  MDU destination register.
REQ-010 bData  in  32  MDU result.
REQ-011 bReady  out  1  buffer can accept; the MDU transfer occurs when bValid&&bReady.
REQ-012 qReg1, qReg2, qDest  in  5 each  decode-stage source and destination registers to check against pending writes.
REQ-013 hazard  out  1  decode must stall this cycle.
REQ-014 pipeStall  out  1  pipeline must present aValid=0 next cycle.
REQ-015 fwdValid1, fwdValid2  out  1 each; fwdData1, fwdData2  out  32 each  bypass results (present only with RF_WB_BYPASS_EN).
REQ-016 regShouldWrite  out  1; writeReg  out  5; writeData  out  32  registered single write port to the register file.

Function
REQ-017 Write-port outputs SHALL be registered, with 1-cycle latency from the winning request to regShouldWrite.
REQ-018 Priority SHALL be: aValid wins; otherwise a non-empty buffer head is written and popped.
REQ-019 A request with destination register 0 SHALL be discarded: no write, no enqueue, but bReady handshake still completes.
REQ-020 bReady SHALL be 1 when count<DEPTH, or when count==DEPTH and a pop occurs this cycle (simultaneous push and pop on a full buffer is allowed).
REQ-021 The buffer SHALL be FIFO ordered, with read and write pointers wrapping modulo DEPTH and count in 0..DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged.
REQ-023 A push into an empty buffer SHALL become poppable no earlier than the next cycle.
REQ-024 The wait counter SHALL increment each cycle the head is present but not popped, clear on pop or when empty, and saturate at MAX_WAIT.
REQ-025 pipeStall SHALL be asserted when waitCnt==MAX_WAIT or count==DEPTH, and SHALL deassert the cycle after the condition clears.
REQ-026 If aValid is asserted the cycle after pipeStall (a protocol violation), A SHALL still win and a sticky internal error flag SHALL be set for assertion checking only.
REQ-027 hazard SHALL be 1 if qDest matches any valid buffer entry register, or if qReg1/qReg2 matches one without bypass; non-zero registers only.
REQ-028 An incoming bReg on a handshake cycle SHALL count as pending for hazard in that same cycle.

Reset
REQ-029 On Reset SHALL set count, pointers and waitCnt to 0, the error flag to 0, regShouldWrite 0, writeReg 0, writeData 0, pipeStall 0 and bReady 1 (after release).
REQ-030 Reset mid-operation SHALL drop all buffered MDU results without writing them; the MDU is reset by the same signal.

Configuration
REQ-031 With RF_WB_BYPASS_EN defined, a source match against a buffer entry SHALL drive fwdValidN=1 and fwdDataN=the youngest matching entry's data, without raising hazard (qDest match still raises hazard).
REQ-032 Without RF_WB_BYPASS_EN, the fwd ports SHALL be absent and any source match SHALL raise hazard.

Structure
REQ-033 Shared package (cpu_pkg) SHALL hold REG_ADDR_W=5, DATA_W=32, and the buffer-entry typedef {reg[5], data[32]}.
REQ-034 One sub-module SHALL be used: wb_fifo (storage, pointers, count, full/empty); arbitration, wait counter and hazard logic stay in the top.

Verification
REQ-035 aValid with aReg=3, aData=0x11 and bValid with bReg=4, bData=0x22 in the same cycle -> write r3=0x11 at T+1, r4=0x22 at T+2.
REQ-036 aValid held every cycle while one MDU result is buffered -> pipeStall=1 after 4 waiting cycles; aValid dropped -> r-head written, pipeStall=0 next cycle.
REQ-037 Three MDU results back-to-back with DEPTH=2 and A busy -> bReady=0 on the third until a pop; order r5, r6, r7 preserved.
REQ-038 bReg=0 handshake -> bReady completes, no write, count stays 0.
REQ-039 Buffer holds r9=0xAB and qReg1=9 -> bypass build: fwdValid1=1, fwdData1=0xAB, hazard=0; non-bypass build: hazard=1; qDest=9 -> hazard=1 in both.
REQ-040 Reset asserted with 2 entries buffered -> count=0, no writes follow, regShouldWrite=0 next cycle.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared CPU definitions for the register-file writeback arbiter.
package cpu_pkg;

   localparam int unsigned REG_ADDR_W = 5;
   localparam int unsigned DATA_W     = 32;

   // One buffered MDU result waiting for the register-file write port
   typedef struct packed {
      logic [REG_ADDR_W-1:0] regAddr;
      logic [DATA_W-1:0]     data;
   } wb_entry_t;

   // Which requester owns the write port this cycle
   typedef enum logic [1:0] {
      SrcNone,
      SrcA,
      SrcBuf
   } wr_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback arbiter bus: pipeline port A, MDU port B, decode hazard query
// and the registered register-file write port.
// Optional feature macro: RF_WB_BYPASS_EN adds the forwarding outputs.
interface regfile_wb_arbiter_if;
   import cpu_pkg::*;

   logic                  aValid;
   logic [REG_ADDR_W-1:0] aReg;
   logic [DATA_W-1:0]     aData;
   logic                  bValid;
   logic [REG_ADDR_W-1:0] bReg;
   logic [DATA_W-1:0]     bData;
   logic                  bReady;
   logic [REG_ADDR_W-1:0] qReg1;
   logic [REG_ADDR_W-1:0] qReg2;
   logic [REG_ADDR_W-1:0] qDest;
   logic                  hazard;
   logic                  pipeStall;
`ifdef RF_WB_BYPASS_EN
   logic                  fwdValid1;
   logic                  fwdValid2;
   logic [DATA_W-1:0]     fwdData1;
   logic [DATA_W-1:0]     fwdData2;
`endif
   logic                  regShouldWrite;
   logic [REG_ADDR_W-1:0] writeReg;
   logic [DATA_W-1:0]     writeData;

`ifdef RF_WB_BYPASS_EN
   modport master (
      output aValid, aReg, aData, bValid, bReg, bData, qReg1, qReg2, qDest,
      input  bReady, hazard, pipeStall, fwdValid1, fwdValid2, fwdData1, fwdData2,
      input  regShouldWrite, writeReg, writeData
   );
   modport slave (
      input  aValid, aReg, aData, bValid, bReg, bData, qReg1, qReg2, qDest,
      output bReady, hazard, pipeStall, fwdValid1, fwdValid2, fwdData1, fwdData2,
      output regShouldWrite, writeReg, writeData
   );
`else
   modport master (
      output aValid, aReg, aData, bValid, bReg, bData, qReg1, qReg2, qDest,
      input  bReady, hazard, pipeStall,
      input  regShouldWrite, writeReg, writeData
   );
   modport slave (
      input  aValid, aReg, aData, bValid, bReg, bData, qReg1, qReg2, qDest,
      output bReady, hazard, pipeStall,
      output regShouldWrite, writeReg, writeData
   );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// MDU writeback buffer: FIFO storage with wrapping pointers and occupancy.
// All entries are exported so the owner can scan them for hazards.
module wb_fifo
   import cpu_pkg::*;
#(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned PTR_W = $clog2(DEPTH),
   localparam int unsigned CNT_W = PTR_W + 1
) (
   input  logic             CLK,
   input  logic             Reset,
   input  logic             i_push,
   input  wb_entry_t        i_pushEntry,
   input  logic             i_pop,
   output wb_entry_t        o_mem [DEPTH],
   output logic [PTR_W-1:0] o_rdPtr,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty,
   output wb_entry_t        o_head
);

   wb_entry_t        r_mem [DEPTH];
   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [CNT_W-1:0] r_count;

   // Pointer and occupancy update; DEPTH is a power of two so pointers wrap naturally
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (i_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage; contents are only meaningful while counted as occupied
   always_ff @(posedge CLK) begin
      if (i_push) r_mem[r_wrPtr] <= i_pushEntry;
   end

   assign o_mem   = r_mem;
   assign o_rdPtr = r_rdPtr;
   assign o_count = r_count;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_head  = r_mem[r_rdPtr];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: pipeline WB (port A, no backpressure)
// and a buffered multi-cycle unit (port B) share one registered write port.
// Also owns the head wait counter, pipeline stall and decode hazard check.
// Optional feature macro: RF_WB_BYPASS_EN forwards buffered results to the
// decode source operands instead of raising a hazard.
module regfile_wb_arbiter
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input logic                 CLK,
   input logic                 Reset,
   regfile_wb_arbiter_if.slave bus
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

   wb_entry_t             w_mem [DEPTH];
   wb_entry_t             w_head;
   wb_entry_t             w_pushEntry;
   logic [PTR_W-1:0]      w_rdPtr;
   logic [CNT_W-1:0]      w_count;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_bFire;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_pipeStall;
   wr_src_e               w_src;
   logic                  w_destHit;
   logic                  w_src1Hit;
   logic                  w_src2Hit;
`ifdef RF_WB_BYPASS_EN
   logic [DATA_W-1:0]     w_src1Data;
   logic [DATA_W-1:0]     w_src2Data;
`endif

   logic [WAIT_W-1:0]     r_waitCnt;
   logic                  r_stallQ;
   logic                  r_protoErr;
   logic                  r_regShouldWrite;
   logic [REG_ADDR_W-1:0] r_writeReg;
   logic [DATA_W-1:0]     r_writeData;

   // A full buffer can still take a result when the head leaves this cycle
   assign bus.bReady  = !w_full || w_pop;
   assign w_bFire     = bus.bValid && bus.bReady;
   // r0 results complete the handshake but are never stored
   assign w_push      = w_bFire && (bus.bReg != '0);
   assign w_pushEntry = '{regAddr: bus.bReg, data: bus.bData};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_wb_fifo (
      .CLK         (CLK),
      .Reset       (Reset),
      .i_push      (w_push),
      .i_pushEntry (w_pushEntry),
      .i_pop       (w_pop),
      .o_mem       (w_mem),
      .o_rdPtr     (w_rdPtr),
      .o_count     (w_count),
      .o_full      (w_full),
      .o_empty     (w_empty),
      .o_head      (w_head)
   );

   // Arbitration: any pipeline request owns the port, buffer head only when A is idle
   always_comb begin
      w_src = SrcNone;
      if (bus.aValid) begin
         if (bus.aReg != '0) w_src = SrcA;
      end else if (!w_empty) begin
         w_src = SrcBuf;
      end
   end

   assign w_pop = (w_src == SrcBuf);

   // Registered single write port to the register file
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_regShouldWrite <= 1'b0;
         r_writeReg       <= '0;
         r_writeData      <= '0;
      end else begin
         r_regShouldWrite <= (w_src != SrcNone);
         case (w_src)
            SrcA: begin
               r_writeReg  <= bus.aReg;
               r_writeData <= bus.aData;
            end
            SrcBuf: begin
               r_writeReg  <= w_head.regAddr;
               r_writeData <= w_head.data;
            end
            default: begin
               r_writeReg  <= r_writeReg;
               r_writeData <= r_writeData;
            end
         endcase
      end
   end

   assign bus.regShouldWrite = r_regShouldWrite;
   assign bus.writeReg       = r_writeReg;
   assign bus.writeData      = r_writeData;

   // Head starvation counter, saturating at MAX_WAIT
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_waitCnt <= '0;
      end else if (w_empty || w_pop) begin
         r_waitCnt <= '0;
      end else if (r_waitCnt != WAIT_W'(MAX_WAIT)) begin
         r_waitCnt <= r_waitCnt + WAIT_W'(1);
      end
   end

   assign w_pipeStall   = (r_waitCnt == WAIT_W'(MAX_WAIT)) || w_full;
   assign bus.pipeStall = w_pipeStall;

   // Sticky flag for a pipeline that kept writing one cycle after being stalled
   always_ff @(posedge CLK) begin
      if (Reset) begin
         r_stallQ   <= 1'b0;
         r_protoErr <= 1'b0;
      end else begin
         r_stallQ   <= w_pipeStall;
         r_protoErr <= r_protoErr || (r_stallQ && bus.aValid);
      end
   end

   a_no_proto_err: assert property (@(posedge CLK) disable iff (Reset) !r_protoErr);

   // Pending-write scan, oldest to youngest so the last match is the youngest;
   // stored and incoming registers are never r0, so a zero query cannot match
   always_comb begin
      logic [PTR_W-1:0] slot;
      w_destHit  = 1'b0;
      w_src1Hit  = 1'b0;
      w_src2Hit  = 1'b0;
`ifdef RF_WB_BYPASS_EN
      w_src1Data = '0;
      w_src2Data = '0;
`endif
      for (int unsigned k = 0; k < DEPTH; k++) begin
         slot = w_rdPtr + PTR_W'(k);
         if (CNT_W'(k) < w_count) begin
            if (w_mem[slot].regAddr == bus.qDest) w_destHit = 1'b1;
            if (w_mem[slot].regAddr == bus.qReg1) begin
               w_src1Hit  = 1'b1;
`ifdef RF_WB_BYPASS_EN
               w_src1Data = w_mem[slot].data;
`endif
            end
            if (w_mem[slot].regAddr == bus.qReg2) begin
               w_src2Hit  = 1'b1;
`ifdef RF_WB_BYPASS_EN
               w_src2Data = w_mem[slot].data;
`endif
            end
         end
      end
      // A result being accepted this cycle is the youngest pending write
      if (w_push) begin
         if (bus.bReg == bus.qDest) w_destHit = 1'b1;
         if (bus.bReg == bus.qReg1) begin
            w_src1Hit  = 1'b1;
`ifdef RF_WB_BYPASS_EN
            w_src1Data = bus.bData;
`endif
         end
         if (bus.bReg == bus.qReg2) begin
            w_src2Hit  = 1'b1;
`ifdef RF_WB_BYPASS_EN
            w_src2Data = bus.bData;
`endif
         end
      end
   end

`ifdef RF_WB_BYPASS_EN
   assign bus.hazard    = w_destHit;
   assign bus.fwdValid1 = w_src1Hit;
   assign bus.fwdValid2 = w_src2Hit;
   assign bus.fwdData1  = w_src1Data;
   assign bus.fwdData2  = w_src2Data;
`else
   assign bus.hazard    = w_destHit || w_src1Hit || w_src2Hit;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus
// random traffic compared against a queue-based reference model.
module tb_regfile_wb_arbiter;
   import cpu_pkg::*;

   localparam int unsigned DEPTH    = 2;
   localparam int unsigned MAX_WAIT = 4;

   logic CLK = 1'b0;
   logic Reset;

   always #5 CLK = ~CLK;

   regfile_wb_arbiter_if bus ();

   regfile_wb_arbiter #(
      .DEPTH    (DEPTH),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model state
   wb_entry_t m_q[$];
   int        m_wait;
   bit        m_prev_stall;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic bit pending(input logic [4:0] r, input bit inc);
      bit hit = 1'b0;
      if (r == 5'd0) return 1'b0;
      foreach (m_q[i]) if (m_q[i].regAddr == r) hit = 1'b1;
      if (inc && bus.bReg == r) hit = 1'b1;
      return hit;
   endfunction

`ifdef RF_WB_BYPASS_EN
   function automatic logic [31:0] youngest(input logic [4:0] r, input bit inc);
      logic [31:0] d = '0;
      foreach (m_q[i]) if (m_q[i].regAddr == r) d = m_q[i].data;
      if (inc && bus.bReg == r) d = bus.bData;
      return d;
   endfunction
`endif

   task automatic drive(input bit av, input logic [4:0] ar, input logic [31:0] ad,
                        input bit bv, input logic [4:0] br, input logic [31:0] bd,
                        input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] qd);
      bus.aValid = av;
      bus.aReg   = ar;
      bus.aData  = ad;
      bus.bValid = bv;
      bus.bReg   = br;
      bus.bData  = bd;
      bus.qReg1  = q1;
      bus.qReg2  = q2;
      bus.qDest  = qd;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
   endtask

   // One clock with the currently driven inputs: check combinational outputs,
   // advance the model, then check the registered write port
   task automatic cycle();
      bit          stall, pop, ready, push, hd, h1, h2, exp_wr;
      logic [4:0]  exp_reg;
      logic [31:0] exp_data;
      int          n0;
      #2;
      n0    = m_q.size();
      stall = (m_wait == MAX_WAIT) || (n0 == DEPTH);
      pop   = !bus.aValid && n0 > 0;
      ready = (n0 < DEPTH) || pop;
      push  = bus.bValid && ready && bus.bReg != 5'd0;
      hd    = pending(bus.qDest, push);
      h1    = pending(bus.qReg1, push);
      h2    = pending(bus.qReg2, push);
      check_eq("bReady", 64'(bus.bReady), 64'(ready));
      check_eq("pipeStall", 64'(bus.pipeStall), 64'(stall));
`ifdef RF_WB_BYPASS_EN
      check_eq("hazard", 64'(bus.hazard), 64'(hd));
      check_eq("fwdValid1", 64'(bus.fwdValid1), 64'(h1));
      check_eq("fwdValid2", 64'(bus.fwdValid2), 64'(h2));
      if (h1) check_eq("fwdData1", 64'(bus.fwdData1), 64'(youngest(bus.qReg1, push)));
      if (h2) check_eq("fwdData2", 64'(bus.fwdData2), 64'(youngest(bus.qReg2, push)));
`else
      check_eq("hazard", 64'(bus.hazard), 64'(hd || h1 || h2));
`endif
      exp_wr   = 1'b0;
      exp_reg  = '0;
      exp_data = '0;
      if (bus.aValid && bus.aReg != 5'd0) begin
         exp_wr   = 1'b1;
         exp_reg  = bus.aReg;
         exp_data = bus.aData;
      end else if (pop) begin
         exp_wr   = 1'b1;
         exp_reg  = m_q[0].regAddr;
         exp_data = m_q[0].data;
      end
      if (pop) void'(m_q.pop_front());
      if (push) m_q.push_back('{regAddr: bus.bReg, data: bus.bData});
      if (n0 == 0 || pop) m_wait = 0;
      else if (m_wait < MAX_WAIT) m_wait++;
      m_prev_stall = stall;
      @(posedge CLK);
      #1;
      check_eq("regShouldWrite", 64'(bus.regShouldWrite), 64'(exp_wr));
      if (exp_wr) begin
         check_eq("writeReg", 64'(bus.writeReg), 64'(exp_reg));
         check_eq("writeData", 64'(bus.writeData), 64'(exp_data));
      end
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      idle();
      @(posedge CLK);
      #1;
      Reset = 1'b0;
      m_q.delete();
      m_wait       = 0;
      m_prev_stall = 1'b0;
      check_eq("rst_regShouldWrite", 64'(bus.regShouldWrite), 64'd0);
      check_eq("rst_writeReg", 64'(bus.writeReg), 64'd0);
      check_eq("rst_writeData", 64'(bus.writeData), 64'd0);
      check_eq("rst_pipeStall", 64'(bus.pipeStall), 64'd0);
      check_eq("rst_bReady", 64'(bus.bReady), 64'd1);
   endtask

   initial begin
      do_reset();

      // Simultaneous A and B: A written first, buffered B next
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd0, 5'd0, 5'd0);
      cycle();
      check_eq("d35_reg_a", 64'(bus.writeReg), 64'd3);
      check_eq("d35_data_a", 64'(bus.writeData), 64'h11);
      idle();
      cycle();
      check_eq("d35_reg_b", 64'(bus.writeReg), 64'd4);
      check_eq("d35_data_b", 64'(bus.writeData), 64'h22);

      // Starved head forces a stall after MAX_WAIT cycles
      do_reset();
      drive(1'b1, 5'd1, 32'h5, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0, 5'd0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 5'd1, 32'h5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
         cycle();
      end
      check_eq("d36_stall_on", 64'(bus.pipeStall), 64'd1);
      drive(1'b1, 5'd1, 32'h5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
      cycle();
      idle();
      cycle();
      check_eq("d36_pop_reg", 64'(bus.writeReg), 64'd7);
      check_eq("d36_stall_off", 64'(bus.pipeStall), 64'd0);

      // Full buffer back-pressures the third MDU result; order preserved
      do_reset();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0, 5'd0);
      #1;
      check_eq("d37_full", 64'(bus.bReady), 64'd0);
      cycle();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77, 5'd0, 5'd0, 5'd0);
      cycle();
      check_eq("d37_w0", 64'(bus.writeReg), 64'd5);
      idle();
      cycle();
      check_eq("d37_w1", 64'(bus.writeReg), 64'd6);
      cycle();
      check_eq("d37_w2", 64'(bus.writeReg), 64'd7);

      // r0 MDU result: handshake completes, nothing written or stored
      do_reset();
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0, 5'd0);
      #1;
      check_eq("d38_ready", 64'(bus.bReady), 64'd1);
      cycle();
      check_eq("d38_nowr", 64'(bus.regShouldWrite), 64'd0);
      idle();
      cycle();
      check_eq("d38_nowr2", 64'(bus.regShouldWrite), 64'd0);

      // Decode queries against a buffered r9
      do_reset();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'hAB, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0, 5'd0);
      #1;
`ifdef RF_WB_BYPASS_EN
      check_eq("d39_fwdv", 64'(bus.fwdValid1), 64'd1);
      check_eq("d39_fwdd", 64'(bus.fwdData1), 64'hAB);
      check_eq("d39_src_hz", 64'(bus.hazard), 64'd0);
`else
      check_eq("d39_src_hz", 64'(bus.hazard), 64'd1);
`endif
      cycle();
      drive(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd9);
      #1;
      check_eq("d39_dest_hz", 64'(bus.hazard), 64'd1);
      cycle();
      idle();
      cycle();

      // Reset with two buffered results drops them
      do_reset();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd5, 32'h55, 5'd0, 5'd0, 5'd0);
      cycle();
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0, 5'd0);
      cycle();
      do_reset();
      idle();
      cycle();
      check_eq("d40_nowr", 64'(bus.regShouldWrite), 64'd0);
      check_eq("d40_ready", 64'(bus.bReady), 64'd1);

      // Random traffic against the model; pipeline honours the stall
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bit av;
         if (i == 300) do_reset();
         av = !m_prev_stall && ($urandom_range(0, 1) == 1);
         drive(av, 5'($urandom_range(0, 7)), $urandom(),
               $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom(),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
